// File: rtl/pipeline_control_pkg.sv
// pipeline_control_pkg: shared state type and constants for pipeline hazard control
package pipeline_control_pkg;
  typedef enum logic [1:0] {BOOT, RUN, MEMWAIT} ctrlState_t;
  localparam int BOOT_CYCLES = 2;
  localparam logic [7:0] MEM_TIMEOUT = 8'd255;
  localparam logic [2:0] LOAD_NONE = 3'b000;
endpackage

// File: rtl/pipeline_control_load_use_detect.sv
// load_use_detect: flags a Decode source that depends on a load still in Execute
module load_use_detect
  import pipeline_control_pkg::*;
(
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic       useRs1D,
  input  logic       useRs2D,
  input  logic [4:0] rdE,
  input  logic       regWriteE,
  input  logic [2:0] memLoadE,
  output logic       loadUse
);
  assign loadUse = (memLoadE != LOAD_NONE) && regWriteE && (rdE != 5'd0) &&
                   ((useRs1D && rs1D == rdE) || (useRs2D && rs2D == rdE));
endmodule

// File: rtl/pipeline_control.sv
// pipeline_control: stall/flush generation with boot sequencing, memory-wait tracking
// and a sticky data-memory timeout flag.
module pipeline_control
  import pipeline_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1D,
  input  logic [4:0]  rs2D,
  input  logic        use_rs1D,
  input  logic        use_rs2D,
  input  logic [4:0]  rdE,
  input  logic        reg_writeE,
  input  logic [2:0]  mem_loadE,
  input  logic        branch_takenE,
  input  logic        mem_reqM,
  input  logic        mem_readyM,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        stallM,
  output logic        flushD,
  output logic        flushE,
  output logic        flushW,
  output logic [31:0] stall_cnt,
  output logic        mem_errorM
);
  localparam logic [1:0] BOOT_LAST = 2'(BOOT_CYCLES - 1);
  ctrlState_t state, nextState;
  logic [1:0] bootCnt;
  logic [7:0] waitCnt, waitNext;
  logic memStall, loadUse;
  logic [6:0] ctl;
  load_use_detect uLoadUse (
    .rs1D(rs1D),
    .rs2D(rs2D),
    .useRs1D(use_rs1D),
    .useRs2D(use_rs2D),
    .rdE(rdE),
    .regWriteE(reg_writeE),
    .memLoadE(mem_loadE),
    .loadUse(loadUse)
  );
  assign memStall = mem_reqM & ~mem_readyM;
  assign {stallF, stallD, stallE, stallM, flushD, flushE, flushW} = ctl;
  // Priority chain: memory stall beats branch redirect beats load-use bubble.
  always_comb begin
    ctl = state == BOOT    ? 7'b0000110 :
          memStall         ? 7'b1111001 :
          branch_takenE    ? 7'b0000110 :
          loadUse          ? 7'b1100010 : 7'b0000000;
    nextState = state == BOOT ? (bootCnt == BOOT_LAST ? RUN : BOOT) :
                memStall      ? MEMWAIT : RUN;
    waitNext = state != MEMWAIT    ? 8'd0 :
               waitCnt == MEM_TIMEOUT ? waitCnt : waitCnt + 8'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      bootCnt    <= '0;
      waitCnt    <= '0;
      stall_cnt  <= '0;
      mem_errorM <= 1'b0;
    end else begin
      state      <= nextState;
      bootCnt    <= state == BOOT ? bootCnt + 2'd1 : 2'd0;
      waitCnt    <= waitNext;
      mem_errorM <= mem_errorM | (waitNext == MEM_TIMEOUT);
      stall_cnt  <= stall_cnt + 32'(stallF && stall_cnt != '1);
    end
  end
endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: directed vectors checked against literals and a cycle model
module tb_pipeline_control;
  localparam logic [31:0] IDLE = 32'h00, FLUSHDE = 32'h06, MEMSTALL = 32'h79, LOADUSE = 32'h62;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] rs1D = '0, rs2D = '0, rdE = '0;
  logic use_rs1D = 1'b0, use_rs2D = 1'b0, reg_writeE = 1'b0;
  logic [2:0] mem_loadE = '0;
  logic branch_takenE = 1'b0, mem_reqM = 1'b0, mem_readyM = 1'b0;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_errorM;
  logic [31:0] stall_cnt, dutOut, expOut;
  int checks = 0, errors = 0;
  int bootLeft = 2, streak = 0;
  logic prevStall = 1'b0, expErr = 1'b0, ms, lu;
  logic [31:0] expCnt = '0;

  pipeline_control dut (
    .clk(clk), .rst_n(rst_n), .rs1D(rs1D), .rs2D(rs2D), .use_rs1D(use_rs1D),
    .use_rs2D(use_rs2D), .rdE(rdE), .reg_writeE(reg_writeE), .mem_loadE(mem_loadE),
    .branch_takenE(branch_takenE), .mem_reqM(mem_reqM), .mem_readyM(mem_readyM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW), .stall_cnt(stall_cnt),
    .mem_errorM(mem_errorM)
  );

  always #5 clk = ~clk;
  assign dutOut = {25'd0, stallF, stallD, stallE, stallM, flushD, flushE, flushW};

  // Expected outputs straight from the hazard rules.
  always_comb begin
    ms = mem_reqM && !mem_readyM;
    lu = (mem_loadE != 3'd0) && reg_writeE && (rdE != 5'd0) &&
         ((use_rs1D && rs1D == rdE) || (use_rs2D && rs2D == rdE));
    expOut = (!rst_n || bootLeft > 0) ? FLUSHDE : ms ? MEMSTALL :
             branch_takenE ? FLUSHDE : lu ? LOADUSE : IDLE;
  end

  // A cycle following a memory stall is a waiting cycle; 255 of them in a row raise the error.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bootLeft <= 2; streak <= 0; prevStall <= 1'b0; expErr <= 1'b0; expCnt <= '0;
    end else if (bootLeft > 0) begin
      bootLeft <= bootLeft - 1;
      prevStall <= 1'b0;
    end else begin
      prevStall <= ms;
      streak <= prevStall ? streak + 1 : 0;
      if (prevStall && streak >= 254) expErr <= 1'b1;
      if (expOut[6] && expCnt != '1) expCnt <= expCnt + 32'd1;
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model outs", dutOut, expOut);
    chk("model stall_cnt", stall_cnt, expCnt);
    chk("model mem_errorM", 32'(mem_errorM), 32'(expErr));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string n, input logic [4:0] r1, input logic [4:0] r2,
                     input logic u1, input logic u2, input logic [4:0] rd, input logic rw,
                     input logic [2:0] ld, input logic br, input logic mq, input logic mr,
                     input logic [31:0] e);
    rs1D = r1; rs2D = r2; use_rs1D = u1; use_rs2D = u2; rdE = rd; reg_writeE = rw;
    mem_loadE = ld; branch_takenE = br; mem_reqM = mq; mem_readyM = mr;
    @(negedge clk);
    chk(n, dutOut, e);
    tick;
  endtask

  initial begin
    tick; tick;
    @(negedge clk);
    chk("reset outs", dutOut, FLUSHDE);
    chk("reset cnt", stall_cnt, 32'd0);
    tick;
    rst_n = 1'b1;
    @(negedge clk); chk("boot1", dutOut, FLUSHDE);
    tick;
    @(negedge clk); chk("boot2", dutOut, FLUSHDE);
    tick;
    @(negedge clk); chk("run idle", dutOut, IDLE);
    tick;
    vec("lu rs2",      0, 5, 0, 1, 5, 1, 3'd2, 0, 0, 0, LOADUSE);
    vec("lu rd0",      0, 0, 0, 1, 0, 1, 3'd2, 0, 0, 0, IDLE);
    vec("lu rs1",      7, 0, 1, 0, 7, 1, 3'd1, 0, 0, 0, LOADUSE);
    vec("no use rs1",  7, 0, 0, 0, 7, 1, 3'd1, 0, 0, 0, IDLE);
    vec("no regwrite", 7, 0, 1, 0, 7, 0, 3'd1, 0, 0, 0, IDLE);
    vec("not load",    7, 0, 1, 0, 7, 1, 3'd0, 0, 0, 0, IDLE);
    vec("lu+branch",   0, 5, 0, 1, 5, 1, 3'd2, 1, 0, 0, FLUSHDE);
    vec("branch",      0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 0, FLUSHDE);
    vec("mem ready lu",0, 5, 0, 1, 5, 1, 3'd2, 0, 1, 1, LOADUSE);
    vec("mem over all",0, 5, 0, 1, 5, 1, 3'd2, 1, 1, 0, MEMSTALL);
    vec("release br",  0, 0, 0, 0, 0, 0, 3'd0, 1, 1, 1, FLUSHDE);
    vec("idle",        0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, IDLE);
    chk("cnt after vec", stall_cnt, 32'd4);
    for (int i = 0; i < 3; i++) vec("memwait", 0, 0, 0, 0, 0, 0, 3'd0, 1, 1, 0, MEMSTALL);
    vec("memwait release br", 0, 0, 0, 0, 0, 0, 3'd0, 1, 1, 1, FLUSHDE);
    vec("after release", 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, IDLE);
    chk("cnt after memwait", stall_cnt, 32'd7);
    mem_reqM = 1'b1; mem_readyM = 1'b0;
    for (int j = 1; j <= 300; j++) begin
      @(negedge clk);
      if (j == 256) chk("err early", 32'(mem_errorM), 32'd0);
      if (j == 257) chk("err set", 32'(mem_errorM), 32'd1);
      tick;
    end
    mem_readyM = 1'b1;
    @(negedge clk); chk("timeout release", dutOut, IDLE);
    tick;
    mem_reqM = 1'b0;
    @(negedge clk);
    chk("err sticky", 32'(mem_errorM), 32'd1);
    chk("cnt after timeout", stall_cnt, 32'd307);
    tick;
    mem_reqM = 1'b1; mem_readyM = 1'b0;
    repeat (5) tick;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midwait rst outs", dutOut, FLUSHDE);
    chk("midwait rst cnt", stall_cnt, 32'd0);
    chk("midwait rst err", 32'(mem_errorM), 32'd0);
    tick;
    rst_n = 1'b1;
    @(negedge clk); chk("reboot1", dutOut, FLUSHDE);
    tick;
    @(negedge clk); chk("reboot2", dutOut, FLUSHDE);
    tick;
    @(negedge clk); chk("reboot run stall", dutOut, MEMSTALL);
    tick;
    mem_reqM = 1'b0;
    repeat (3) tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
